sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
Parametrised successor to the two-source SRAM controller. It arbitrates NUM_CH requesters (DMA, pixel, and future engines) onto one single-port SRAM with a single clock, so no clock switching is needed. It supports round-robin or fixed-priority grant, locked bursts with a fairness cap, and tagged read-data return with configurable SRAM read latency.

Parameters:
NUM_CH, 2, number of requester channels (>=2)
DATA_W, 32, SRAM data width
ADDR_W, 9, SRAM address width
RD_LAT, 1, SRAM read latency in cycles from the capturing edge to valid rdata (>=1)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins
BURST_MAX, 16, maximum beats a channel may hold the lock (>=1)

Ports:
clk  in  1  block clock
rst  in  1  asynchronous reset, active-high
req_valid_i  in  NUM_CH  per-channel request valid
req_ready_o  out  NUM_CH  per-channel accept; beat transfers when valid&ready
req_wr_i  in  NUM_CH  1 = write, 0 = read
req_last_i  in  NUM_CH  final beat of the burst; 1 on a single access
req_addr_i  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_CH*DATA_W  packed write data
rsp_valid_o  out  NUM_CH  one-hot read-data valid
rsp_rdata_o  out  DATA_W  read data, shared by all channels
sram_cs_n_o  out  1  SRAM chip select, active-low, registered
sram_wr_n_o  out  1  SRAM write enable, active-low, registered
sram_addr_o  out  ADDR_W  SRAM address, registered
sram_wdata_o  out  DATA_W  SRAM write data, registered
sram_rdata_i  in  DATA_W  SRAM read data
busy_o  out  1  lock held or read in flight

Behaviour:
- Reset values:
  - req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, busy_o = 0.
  - sram_cs_n_o = 1, sram_wr_n_o = 1, sram_addr_o = 0, sram_wdata_o = 0.
  - state = IDLE, rr_ptr = NUM_CH-1 (so ch0 has first priority), beat_cnt = 0, tag pipeline cleared.
- FSM states: IDLE and LOCK. lock_ch and beat_cnt are registers.
- IDLE:
  - The grant is combinational over req_valid_i.
  - ARB_MODE 0: search starts at rr_ptr+1 and wraps modulo NUM_CH.
  - ARB_MODE 1: the lowest valid index wins.
  - req_ready_o is one-hot at the winner; all zeros if nothing is valid.
  - Accepted beat with last=1: stay IDLE and set rr_ptr = winner.
  - Accepted beat with last=0 and BURST_MAX>1: go to LOCK, set lock_ch = winner, beat_cnt = 1.
- LOCK:
  - req_ready_o[lock_ch] = 1; all other channels read 0.
  - If the locked channel drops valid, the lock holds and idle cycles issue cs_n = 1.
  - Each accepted beat increments beat_cnt.
  - Leave to IDLE on the accepted beat where last=1 or beat_cnt+1 == BURST_MAX. rr_ptr = lock_ch, beat_cnt = 0.
  - After a forced release, the channel re-arbitrates for its remaining beats.
- SRAM issue:
  - A beat accepted in cycle N drives cs_n = 0, wr_n = ~wr, addr and wdata in cycle N+1.
  - cs_n = 1 in any cycle after no accept. Maximum one access per cycle; back-to-back accepts give continuous cs_n = 0.
- Read return:
  - Each read pushes a valid+channel tag into a (1+RD_LAT)-deep shift pipeline. Writes push an empty tag.
  - A read accepted in cycle N gives rsp_valid_o[ch] = 1 and rsp_rdata_o = sram_rdata_i in cycle N+1+RD_LAT, for one cycle.
  - Responses are not backpressured; requesters must sink them.
  - Responses return in acceptance order.
- Ordering: the SRAM sees beats in acceptance order. A read after a write to the same address returns the new data.
- busy_o = (state == LOCK) | any tag valid in the pipeline.
- Reset mid-operation: everything returns to reset values immediately. In-flight reads are dropped and no rsp_valid_o fires afterwards.
- Simultaneous release and new request: a beat that ends a lock and a different channel's valid in the same cycle do not conflict. The other channel gets its grant the next cycle, with rr_ptr already updated.

Test Plan:
- Single read: ch0 read at addr 0x005, with the SRAM holding 0xDEADBEEF, RD_LAT = 1, accepted cycle 10 -> cs_n = 0 and wr_n = 1 at cycle 11; rsp_valid_o = 2'b01 and rdata = 0xDEADBEEF at cycle 12.
- Round-robin: ch0 and ch1 both hold valid single writes continuously -> grants alternate 0,1,0,1 over 4 cycles with cs_n = 0 throughout.
- Burst lock: ch1 sends a 4-beat write burst to 0x010-0x013 while ch0 is valid -> ch0 ready stays 0 until the beat with last is accepted; ch0 is granted the next cycle.
- Burst cap: BURST_MAX = 4, ch0 sends 6 beats with last only on beat 6, ch1 valid -> lock releases after beat 4; ch1 is granted; ch0 resumes beats 5-6 afterwards.
- Write-then-read: ch0 writes 0x12345678 to 0x0A0, then ch1 reads 0x0A0 in the next cycle -> ch1 rsp_rdata_o = 0x12345678.
- Reset mid-read: assert rst one cycle after a read is accepted -> no rsp_valid_o afterwards; all outputs at reset values; busy_o = 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// NUM_CH requesters share one single-port SRAM: round-robin/fixed grant, capped burst lock, tagged reads.
// SRAM pins are driven the cycle after accept, read data returns RD_LAT later; responses are never stalled.
module sram_port_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int RD_LAT    = 1,
  parameter int ARB_MODE  = 0,
  parameter int BURST_MAX = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid_i,
  output logic [NUM_CH-1:0]          req_ready_o,
  input  logic [NUM_CH-1:0]          req_wr_i,
  input  logic [NUM_CH-1:0]          req_last_i,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_CH-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       sram_cs_n_o,
  output logic                       sram_wr_n_o,
  output logic [ADDR_W-1:0]          sram_addr_o,
  output logic [DATA_W-1:0]          sram_wdata_o,
  input  logic [DATA_W-1:0]          sram_rdata_i,
  output logic                       busy_o
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    lock_ch_q, lock_ch_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                cs_n_q, cs_n_d;
  logic                wr_n_q, wr_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [RD_LAT:0]             tag_vld_q;
  logic [RD_LAT:0][PTR_W-1:0]  tag_ch_q;

  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PTR_W-1:0]    cand;
  logic                acc_any;
  logic [PTR_W-1:0]    acc_ch;
  logic                acc_wr;
  logic                acc_last;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  // Descending scan so the highest-priority candidate is the final one written.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        cand = PTR_W'(i);
        if (req_valid_i[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_CH);
        if (req_valid_i[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst) begin
      if (state_q == LOCK) begin
        req_ready_o[lock_ch_q] = 1'b1;
      end else if (gnt_vld) begin
        req_ready_o[gnt_idx] = 1'b1;
      end
    end
  end

  assign acc_any = |(req_valid_i & req_ready_o);
  assign acc_ch  = (state_q == LOCK) ? lock_ch_q : gnt_idx;

  always_comb begin
    acc_wr    = 1'b0;
    acc_last  = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc_ch == PTR_W'(i)) begin
        acc_wr    = req_wr_i[i];
        acc_last  = req_last_i[i];
        acc_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
        acc_wdata = req_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_ch_d  = lock_ch_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (acc_any) begin
          if (acc_last || BURST_MAX == 1) begin
            rr_ptr_d = acc_ch;
          end else begin
            state_d    = LOCK;
            lock_ch_d  = acc_ch;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCK: begin
        if (acc_any) begin
          // A capped release hands the remaining beats back to normal arbitration.
          if (acc_last || (beat_cnt_q + 1'b1) == CNT_W'(BURST_MAX)) begin
            state_d    = IDLE;
            rr_ptr_d   = lock_ch_q;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d  = ~acc_any;
    wr_n_d  = ~(acc_any & acc_wr);
    addr_d  = acc_any ? acc_addr : addr_q;
    wdata_d = acc_any ? acc_wdata : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= PTR_W'(NUM_CH - 1);
      lock_ch_q  <= '0;
      beat_cnt_q <= '0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      tag_vld_q  <= '0;
      tag_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_ch_q  <= lock_ch_d;
      beat_cnt_q <= beat_cnt_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tag_vld_q  <= {tag_vld_q[RD_LAT-1:0], acc_any & ~acc_wr};
      tag_ch_q   <= {tag_ch_q[RD_LAT-1:0], acc_ch};
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (tag_vld_q[RD_LAT]) begin
      rsp_valid_o[tag_ch_q[RD_LAT]] = 1'b1;
    end
  end

  assign rsp_rdata_o  = tag_vld_q[RD_LAT] ? sram_rdata_i : '0;
  assign sram_cs_n_o  = cs_n_q;
  assign sram_wr_n_o  = wr_n_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign busy_o       = (state_q == LOCK) | (|tag_vld_q);

endmodule
